// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: valid tracking and clock-enable sequencing for the IF/ID/EX/MEM/WB stage registers.
// Optional retire/stall performance counters are built when PIPE_STAGE_CTRL_PERF_EN is defined.
module pipe_stage_ctrl #(
  parameter int NSTAGES = 5,
  parameter int CNT_W   = 32
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               en,
  input  logic               fetch_valid,
  output logic               fetch_ready,
  input  logic [NSTAGES-1:0] hold,
  input  logic               flush,
  input  logic [NSTAGES-1:0] flush_mask,
  output logic [NSTAGES-1:0] stage_ce,
  output logic [NSTAGES-1:0] stage_valid,
  output logic               retire
`ifdef PIPE_STAGE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]   retire_count,
  output logic [CNT_W-1:0]   stall_count
`endif
);

  if (NSTAGES < 2 || CNT_W < 1) begin : g_param_check
    $error("pipe_stage_ctrl: NSTAGES must be >= 2 and CNT_W >= 1");
  end

  logic [NSTAGES-1:0] valid;
  logic [NSTAGES-1:0] valid_nxt;
  logic [NSTAGES-1:0] kill;
  logic [NSTAGES-1:0] leave;
  logic [NSTAGES-1:0] acc;
  logic [NSTAGES-1:0] in_v;
  logic [NSTAGES-1:0] ce_raw;

  assign kill = flush ? flush_mask : '0;

  // Room propagates from the tail backward: a stage can take new data if it is
  // empty, is being flushed, or its occupant moves on this cycle.
  always_comb begin
    logic room;
    room  = 1'b1;
    leave = '0;
    acc   = '0;
    for (int i = NSTAGES - 1; i >= 0; i--) begin
      leave[i] = valid[i] & ~hold[i] & ~kill[i] & room;
      room     = ~valid[i] | leave[i] | kill[i];
      acc[i]   = room;
    end
  end

  assign in_v   = {valid[NSTAGES-2:0] & ~hold[NSTAGES-2:0] & ~kill[NSTAGES-2:0],
                   fetch_valid & ~kill[0]};
  assign ce_raw = {NSTAGES{en}} & acc & in_v & ~kill;

  assign stage_ce    = RST_N ? ce_raw : '0;
  assign fetch_ready = RST_N & en & acc[0] & ~kill[0];
  assign retire      = RST_N & en & leave[NSTAGES-1];
  assign stage_valid = valid;

  // Flush wins over everything, including a frozen pipe.
  always_comb begin
    valid_nxt = valid;
    for (int i = 0; i < NSTAGES; i++) begin
      if (kill[i]) begin
        valid_nxt[i] = 1'b0;
      end else if (!en) begin
        valid_nxt[i] = valid[i];
      end else if (ce_raw[i]) begin
        valid_nxt[i] = 1'b1;
      end else if (leave[i]) begin
        valid_nxt[i] = 1'b0;
      end else begin
        valid_nxt[i] = valid[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid <= '0;
    end else begin
      valid <= valid_nxt;
    end
  end

`ifdef PIPE_STAGE_CTRL_PERF_EN
  logic stall_evt;

  // A stall is a presented fetch that is refused for any reason other than a flush.
  assign stall_evt = en & fetch_valid & ~fetch_ready & ~flush;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      retire_count <= '0;
      stall_count  <= '0;
    end else begin
      if (retire) begin
        retire_count <= retire_count + CNT_W'(1);
      end
      if (stall_evt) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end
`endif

endmodule
